// File: rtl/bwd_search_unit.sv
// Backward BFS search unit: expands the predecessor frontier one level per
// coordinator step, fetching predecessor rows over a req/ack port, and
// detects a meet with the forward search's visited set or frontier exhaustion.
module bwd_search_unit #(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          start,
  input  logic [AW-1:0] goal,
  input  logic          step,
  input  logic [N-1:0]  fwd_visited,
  output logic          row_req,
  output logic [AW-1:0] row_addr,
  input  logic          row_ack,
  input  logic [N-1:0]  row_data,
  output logic          busy,
  output logic          step_done,
  output logic [N-1:0]  frontier,
  output logic [N-1:0]  visited,
  output logic [7:0]    level,
  output logic          meet,
  output logic [AW-1:0] meet_node,
  output logic          exhausted
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READY, S_SCAN, S_REQ, S_COMMIT, S_DONE
  } state_t;

  localparam logic [AW:0]   N_EXT = (AW+1)'(N);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  frontier_q, frontier_d;
  logic [N-1:0]  visited_q, visited_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    level_q, level_d;
  logic          meet_q, meet_d;
  logic [AW-1:0] meet_node_q, meet_node_d;
  logic          exhausted_q, exhausted_d;

  logic          goal_ok;
  logic [N-1:0]  hit;
  logic          hit_found;
  logic [AW-1:0] hit_low;

  assign goal_ok = ({1'b0, goal} < N_EXT);

  // Lowest set index of the backward/forward intersection
  always_comb begin
    hit       = visited_q & fwd_visited;
    hit_low   = '0;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (hit[i] && !hit_found) begin
        hit_low   = AW'(i);
        hit_found = 1'b1;
      end
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q     <= S_IDLE;
      frontier_q  <= '0;
      visited_q   <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      level_q     <= '0;
      meet_q      <= 1'b0;
      meet_node_q <= '0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frontier_q  <= frontier_d;
      visited_q   <= visited_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      meet_q      <= meet_d;
      meet_node_q <= meet_node_d;
      exhausted_q <= exhausted_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d     = state_q;
    frontier_d  = frontier_q;
    visited_d   = visited_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    level_d     = level_q;
    meet_d      = meet_q;
    meet_node_d = meet_node_q;
    exhausted_d = exhausted_q;
    case (state_q)
      S_IDLE, S_READY, S_DONE: begin
        if (start && goal_ok) begin
          frontier_d  = {{(N-1){1'b0}}, 1'b1} << goal;
          visited_d   = {{(N-1){1'b0}}, 1'b1} << goal;
          level_d     = '0;
          meet_d      = 1'b0;
          meet_node_d = '0;
          exhausted_d = 1'b0;
          acc_d       = '0;
          state_d     = S_CHECK;
        end else if (state_q == S_READY && step) begin
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_CHECK: begin
        if (hit_found) begin
          meet_d      = 1'b1;
          meet_node_d = hit_low;
          state_d     = S_DONE;
        end else if (frontier_q == '0) begin
          exhausted_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_READY;
        end
      end
      S_SCAN: begin
        if (frontier_q[idx_q]) begin
          state_d = S_REQ;
        end else if (idx_q == LAST) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_REQ: begin
        if (row_ack) begin
          acc_d = acc_q | row_data;
          if (idx_q == LAST) begin
            state_d = S_COMMIT;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_SCAN;
          end
        end
      end
      S_COMMIT: begin
        frontier_d = acc_q & ~visited_q;
        visited_d  = visited_q | acc_q;
        level_d    = (level_q == 8'hFF) ? level_q : level_q + 8'd1;
        state_d    = S_CHECK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign row_req   = (state_q == S_REQ);
  assign row_addr  = idx_q;
  assign busy      = (state_q == S_SCAN) || (state_q == S_REQ) || (state_q == S_COMMIT);
  assign step_done = (state_q == S_COMMIT);
  assign frontier  = frontier_q;
  assign visited   = visited_q;
  assign level     = level_q;
  assign meet      = meet_q;
  assign meet_node = meet_node_q;
  assign exhausted = exhausted_q;

endmodule

// File: tb/tb_bwd_search_unit.sv
// Self-checking bench for bwd_search_unit: directed scenarios plus random
// graphs, compared against a set-level BFS model of the backward search.
module tb_bwd_search_unit;

  localparam int N  = 16;
  localparam int AW = 4;

  logic          m_clock;
  logic          p_reset;
  logic          start;
  logic [AW-1:0] goal;
  logic          step;
  logic [N-1:0]  fwd_visited;
  logic          row_req;
  logic [AW-1:0] row_addr;
  logic          row_ack;
  logic [N-1:0]  row_data;
  logic          busy;
  logic          step_done;
  logic [N-1:0]  frontier;
  logic [N-1:0]  visited;
  logic [7:0]    level;
  logic          meet;
  logic [AW-1:0] meet_node;
  logic          exhausted;

  bwd_search_unit #(.N(N), .AW(AW)) dut (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .start       (start),
    .goal        (goal),
    .step        (step),
    .fwd_visited (fwd_visited),
    .row_req     (row_req),
    .row_addr    (row_addr),
    .row_ack     (row_ack),
    .row_data    (row_data),
    .busy        (busy),
    .step_done   (step_done),
    .frontier    (frontier),
    .visited     (visited),
    .level       (level),
    .meet        (meet),
    .meet_node   (meet_node),
    .exhausted   (exhausted)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  int n_checks = 0;
  int n_err    = 0;

  // Graph: pred[j] bit i set means edge i->j
  logic [N-1:0] pred [N];

  // Reference model state
  logic [N-1:0] m_front, m_vis;
  int           m_level, m_node;
  bit           m_meet, m_exh, m_done;
  int           last_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic model_reset();
    m_front = '0; m_vis = '0; m_level = 0; m_node = 0;
    m_meet = 0; m_exh = 0; m_done = 0;
  endtask

  // Level check: intersection first, then empty frontier
  task automatic model_eval();
    logic [N-1:0] inter;
    inter = m_vis & fwd_visited;
    if (inter != '0) begin
      m_meet = 1; m_done = 1;
      for (int i = N - 1; i >= 0; i--) if (inter[i]) m_node = i;
    end else if (m_front == '0) begin
      m_exh = 1; m_done = 1;
    end
  endtask

  // One BFS level: union of predecessor sets of the frontier
  task automatic model_step();
    logic [N-1:0] nxt;
    nxt = '0;
    for (int i = 0; i < N; i++) if (m_front[i]) nxt |= pred[i];
    m_front = nxt & ~m_vis;
    m_vis   = m_vis | nxt;
    m_level = (m_level < 255) ? m_level + 1 : 255;
  endtask

  task automatic clear_graph();
    for (int j = 0; j < N; j++) pred[j] = '0;
  endtask

  task automatic do_start(input int g);
    start = 1'b1;
    goal  = AW'(g);
    tick();
    start = 1'b0;
    model_reset();
    m_front = N'(1) << g;
    m_vis   = N'(1) << g;
    check("start_visited", visited, m_vis);
    check("start_frontier", frontier, m_front);
    check("start_level", level, 0);
    check("start_meet", meet, 0);
    check("start_exh", exhausted, 0);
    check("start_rowreq", row_req, 0);
    model_eval();
    tick();
    check("chk_meet", meet, m_meet);
    check("chk_node", meet_node, m_node);
    check("chk_exh", exhausted, m_exh);
    check("chk_rowreq", row_req, 0);
    check("chk_busy", busy, 0);
  endtask

  task automatic run_step(input int mind, input int maxd, input bit inject);
    int  exp_q[$];
    int  cyc, waits, waited, d, f, ea;
    bit  done, in_req;
    logic [AW-1:0] cur;
    f = 0;
    for (int i = 0; i < N; i++) if (m_front[i]) begin exp_q.push_back(i); f++; end
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 0; waits = 0; waited = 0; d = 0; done = 0; in_req = 0; cur = '0;
    while (!done && cyc < 400) begin
      cyc++;
      start = inject && (cyc == 1);
      step  = inject && (cyc == 1);
      if (inject && cyc == 1) goal = AW'($urandom_range(0, N - 1));
      check("busy_in_step", busy, 1);
      if (step_done) begin
        done = 1;
        row_ack = 1'b0;
      end else if (row_req) begin
        if (!in_req) begin
          in_req = 1;
          cur    = row_addr;
          d      = $urandom_range(mind, maxd);
          waited = 0;
          ea     = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
          check("req_addr", row_addr, ea);
        end else begin
          check("req_addr_stable", row_addr, cur);
        end
        if (waited < d) begin
          row_ack = 1'b0; waited++; waits++;
        end else begin
          row_ack  = 1'b1;
          row_data = pred[row_addr];
          in_req   = 0;
        end
      end else begin
        row_ack  = 1'($urandom_range(0, 1));
        row_data = N'($urandom);
      end
      if (!done) tick();
    end
    start = 1'b0; step = 1'b0; row_ack = 1'b0;
    check("step_done_seen", done, 1);
    model_step();
    last_cyc = cyc;
    check("step_latency", cyc, N + f + 1 + waits);
    check("req_all_issued", exp_q.size(), 0);
    tick();
    check("commit_frontier", frontier, m_front);
    check("commit_visited", visited, m_vis);
    check("commit_level", level, m_level);
    check("commit_busy", busy, 0);
    check("commit_stepdone", step_done, 0);
    model_eval();
    tick();
    check("post_meet", meet, m_meet);
    check("post_node", meet_node, m_node);
    check("post_exh", exhausted, m_exh);
  endtask

  // In DONE a step must do nothing
  task automatic poke_done();
    logic [N-1:0] v;
    v = visited;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("done_step_busy", busy, 0);
    tick();
    check("done_hold_visited", visited, v);
    check("done_hold_busy", busy, 0);
  endtask

  initial begin
    int k, s;
    p_reset = 1'b0; start = 1'b0; goal = '0; step = 1'b0;
    fwd_visited = '0; row_ack = 1'b0; row_data = '0;
    clear_graph();
    model_reset();
    repeat (3) tick();
    check("rst_rowreq", row_req, 0);
    check("rst_busy", busy, 0);
    check("rst_stepdone", step_done, 0);
    check("rst_meet", meet, 0);
    check("rst_exh", exhausted, 0);
    check("rst_frontier", frontier, 0);
    check("rst_visited", visited, 0);
    check("rst_level", level, 0);
    check("rst_node", meet_node, 0);
    check("rst_addr", row_addr, 0);
    p_reset = 1'b1;
    tick();

    // Immediate meet at the goal
    fwd_visited = 16'h0004;
    do_start(2);
    check("d40_meet", meet, 1);
    check("d40_node", meet_node, 2);
    check("d40_level", level, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d40_no_req", row_req, 0);
    end
    poke_done();

    // Two steps ending in a meet at node 0
    clear_graph();
    pred[5] = 16'h0018; pred[3] = 16'h0003; pred[4] = 16'h0003;
    fwd_visited = 16'h0001;
    do_start(5);
    run_step(0, 0, 0);
    check("d41_cycle", last_cyc, 18);
    check("d41_frontier", frontier, 16'h0018);
    check("d41_visited", visited, 16'h0038);
    check("d41_level", level, 1);
    check("d41_meet", meet, 0);
    run_step(0, 0, 0);
    check("d42_frontier", frontier, 16'h0003);
    check("d42_visited", visited, 16'h003B);
    check("d42_meet", meet, 1);
    check("d42_node", meet_node, 0);

    // Exhaustion on a self-loop
    clear_graph();
    pred[7] = 16'h0080;
    fwd_visited = '0;
    do_start(7);
    run_step(0, 0, 0);
    check("d43_frontier", frontier, 0);
    check("d43_exh", exhausted, 1);
    check("d43_meet", meet, 0);
    check("d43_level", level, 1);

    // Three-cycle ack wait with start/step poked mid-scan
    clear_graph();
    pred[5] = 16'h0018;
    fwd_visited = 16'h8000;
    do_start(5);
    run_step(3, 3, 1);
    check("d44_cycle", last_cyc, 21);
    check("d44_visited", visited, 16'h0038);

    // Reset while a row request is outstanding
    clear_graph();
    pred[5] = 16'h0018;
    fwd_visited = 16'h0001;
    do_start(5);
    step = 1'b1;
    tick();
    step = 1'b0;
    row_ack = 1'b0;
    k = 0;
    while (!row_req && k < 40) begin tick(); k++; end
    check("rst_reached_req", row_req, 1);
    tick();
    p_reset = 1'b0;
    #1;
    check("rst_mid_rowreq", row_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_visited", visited, 0);
    check("rst_mid_addr", row_addr, 0);
    repeat (2) tick();
    p_reset = 1'b1;
    row_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_after_rowreq", row_req, 0);
      check("rst_after_busy", busy, 0);
    end
    row_ack = 1'b0;
    model_reset();

    // Random graphs and forward sets
    for (int t = 0; t < 25; t++) begin
      for (int j = 0; j < N; j++) pred[j] = N'($urandom & $urandom & $urandom);
      fwd_visited = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom & $urandom & $urandom);
      do_start($urandom_range(0, N - 1));
      s = 0;
      while (!m_done && s < N + 2) begin
        run_step(0, 3, $urandom_range(0, 3) == 0);
        s++;
      end
      check("rand_terminated", m_done, 1);
      poke_done();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
